// File: rtl/tick_prescaler_pkg.sv
// Shared types and helpers for the tick prescaler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tick_prescaler_pkg;

  // Prescaler control states: RUN counts, HOLD freezes, DONE parks after a one-shot tick.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Smallest divisor that still yields a one-cycle tick separated by idle cycles.
  localparam int MIN_DIV = 2;

  // Raise a requested divisor to the legal floor.
  function automatic int unsigned clamp_div(input int unsigned value, input int unsigned floor_div);
    return (value < floor_div) ? floor_div : value;
  endfunction

endpackage

// File: rtl/tick_prescaler_div_shadow.sv
// Divisor shadow: accepts divisor loads, clamps them, holds them until a period boundary.
// Latency: load lands in active_div next edge when direct, else on the edge of the next apply strobe.
// Backpressure: div_ready drops while a pending divisor waits; it rises again after apply.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   direct      prescaler idle/done: accepted loads bypass the shadow
//   apply       terminal-count strobe from the counter; promotes the pending divisor
//   div_valid   load request; div_value the requested divisor
//   div_ready   can accept (no divisor pending)
//   active_div  divisor currently used by the counter
module tick_prescaler_div_shadow #(
  parameter int WIDTH       = 9,
  parameter int DEFAULT_DIV = 300,
  parameter int MIN_DIV     = tick_prescaler_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             direct,
  input  logic             apply,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic [WIDTH-1:0] active_div
);
  import tick_prescaler_pkg::*;

  logic             pending;
  logic [WIDTH-1:0] pending_div;
  logic [WIDTH-1:0] clamped;
  logic             accept;

  assign clamped   = WIDTH'(clamp_div(32'(div_value), 32'(MIN_DIV)));
  assign div_ready = !pending;
  assign accept    = div_valid && div_ready;

  // An accept can only happen with nothing pending, so an apply and a new
  // pending value never fight: the old value is promoted, the new one waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      pending_div <= '0;
      active_div  <= WIDTH'(DEFAULT_DIV);
    end else begin
      if (apply && pending) begin
        active_div <= pending_div;
        pending    <= 1'b0;
      end
      if (accept) begin
        if (direct) begin
          active_div <= clamped;
        end else begin
          pending_div <= clamped;
          pending     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// Programmable clock-enable generator: one-cycle tick every active_div enabled cycles.
// Latency: first tick registered on the active_div-th edge with en high; tick is a flop output.
// Backpressure: en low freezes the count; divisor port stalls (div_ready=0) while a load is pending.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          count enable; oneshot selects one-shot mode, sampled on IDLE->RUN
//   div_valid / div_value / div_ready   divisor reload handshake
//   tick        one-cycle enable pulse; busy = RUN or HOLD; count = current counter value
module tick_prescaler #(
  parameter int WIDTH       = 9,
  parameter int DEFAULT_DIV = 300,
  parameter int MIN_DIV     = tick_prescaler_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             oneshot,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);
  import tick_prescaler_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             mode_r;
  logic [WIDTH-1:0] active_div;
  logic             advance;
  logic             terminal;
  logic             wrap;
  logic             direct;

  // Every enabled edge counts, including the one leaving IDLE or HOLD, so the
  // tick lands exactly active_div enabled edges after start. count is 0 in
  // IDLE and DONE, and active_div >= 2, so the IDLE edge never wraps.
  assign advance  = en && (state != DONE);
  assign terminal = (count == active_div - WIDTH'(1));
  assign wrap     = advance && terminal;
  assign direct   = (state == IDLE) || (state == DONE);
  assign busy     = (state == RUN) || (state == HOLD);

  tick_prescaler_div_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV),
    .MIN_DIV     (MIN_DIV)
  ) u_div_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .direct     (direct),
    .apply      (wrap),
    .div_valid  (div_valid),
    .div_value  (div_value),
    .div_ready  (div_ready),
    .active_div (active_div)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en)                    state_nxt = HOLD;
        else if (terminal && mode_r) state_nxt = DONE;
      end
      // Resuming edge also counts, so it may itself be the one-shot tick.
      HOLD: if (en) state_nxt = (terminal && mode_r) ? DONE : RUN;
      DONE: if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      tick   <= 1'b0;
      mode_r <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        count <= '0;
      end else if (advance) begin
        count <= count + WIDTH'(1);
      end
      if ((state == IDLE) && en) begin
        mode_r <= oneshot;
      end
    end
  end

endmodule
